// File: rtl/commit_trace_sequencer.sv
// Commit trace sequencer: compacts per-cycle retirement and exception records into program
// order, tags them with a sequence number and buffers them for one valid/ready trace sink.
module commit_trace_sequencer #(
    parameter int NrCommitPorts = 2,
    parameter int PayloadWidth  = 128,
    parameter int FifoDepth     = 8,
    parameter int SeqWidth      = 8
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    enable_i,
    input  logic                                    clear_i,
    input  logic [NrCommitPorts-1:0]                commit_valid_i,
    input  logic [NrCommitPorts*PayloadWidth-1:0]   commit_data_i,
    input  logic                                    exc_valid_i,
    input  logic [PayloadWidth-1:0]                 exc_data_i,
    output logic                                    trace_valid_o,
    input  logic                                    trace_ready_i,
    output logic [SeqWidth+2+PayloadWidth-1:0]      trace_data_o,
    output logic [$clog2(FifoDepth):0]              level_o,
    output logic [31:0]                             drop_cnt_o,
    output logic                                    overflow_o,
    output logic                                    state_o
);

    // Output handshake: a head record is transferred on a cycle where trace_valid_o and
    // trace_ready_i are both high; while valid is high and ready low, valid and data hold.

    localparam int AW = $clog2(FifoDepth);
    localparam int LW = AW + 1;
    localparam int CW = LW + 1;
    localparam int DW = SeqWidth + 2 + PayloadWidth;
    localparam int NW = NrCommitPorts + 2;
    localparam int SI = $clog2(NW);

    localparam logic [1:0] KIND_COMMIT = 2'b00;
    localparam logic [1:0] KIND_EXC    = 2'b01;
    localparam logic [1:0] KIND_LOSS   = 2'b10;

    typedef enum logic {
        NORMAL = 1'b0,
        LOSSY  = 1'b1
    } state_t;

    state_t                  state;
    logic [LW-1:0]           wr_ptr;
    logic [LW-1:0]           rd_ptr;
    logic [SeqWidth-1:0]     seq;
    logic [31:0]             lost;
    logic [31:0]             drop_cnt;
    logic                    overflow;
    logic [DW-1:0]           mem [FifoDepth];

    logic [LW-1:0]           level;
    logic                    empty;
    logic                    pop;
    logic [CW-1:0]           free;
    logic [CW-1:0]           n_rec;
    logic [CW-1:0]           need;
    logic                    accept;
    logic [CW-1:0]           wr_cnt;
    logic [SI:0]             slot;
    logic                    sat;
    logic [PayloadWidth-1:0] marker_payload;
    logic [DW-1:0]           wr_ent [NW];

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [CW-1:0] b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    assign level         = wr_ptr - rd_ptr;
    assign empty         = (wr_ptr == rd_ptr);
    assign trace_valid_o = !empty;
    assign trace_data_o  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign pop           = trace_valid_o & trace_ready_i;
    // A same-cycle pop frees a slot, so a full FIFO can still take one record.
    assign free          = CW'(FifoDepth) - CW'(level) + CW'(pop);
    assign level_o       = level;
    assign drop_cnt_o    = drop_cnt;
    assign overflow_o    = overflow;
    assign state_o       = state;

    assign sat            = (PayloadWidth < 32) && ((lost >> PayloadWidth) != 32'd0);
    assign marker_payload = sat ? '1 : PayloadWidth'(lost);

    always_comb begin
        n_rec = '0;
        for (int p = 0; p < NrCommitPorts; p++) begin
            n_rec = n_rec + CW'(commit_valid_i[p] & enable_i);
        end
        n_rec  = n_rec + CW'(exc_valid_i & enable_i);
        need   = (state == LOSSY) ? n_rec + CW'(1) : n_rec;
        accept = (need <= free);
        wr_cnt = accept ? need : '0;

        // Compact into program order: marker (if pending), ports oldest first, exception last.
        for (int i = 0; i < NW; i++) begin
            wr_ent[i] = '0;
        end
        slot = '0;
        if (state == LOSSY) begin
            wr_ent[0] = {seq, KIND_LOSS, marker_payload};
            slot      = 1;
        end
        for (int p = 0; p < NrCommitPorts; p++) begin
            if (commit_valid_i[p] & enable_i) begin
                wr_ent[slot[SI-1:0]] = {seq + SeqWidth'(slot), KIND_COMMIT,
                                        commit_data_i[p*PayloadWidth +: PayloadWidth]};
                slot = slot + 1'b1;
            end
        end
        if (exc_valid_i & enable_i) begin
            wr_ent[slot[SI-1:0]] = {seq + SeqWidth'(slot), KIND_EXC, exc_data_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && !clear_i && accept) begin
            for (int i = 0; i < NW; i++) begin
                if (CW'(i) < wr_cnt) begin
                    mem[wr_ptr[AW-1:0] + AW'(i)] <= wr_ent[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            seq      <= '0;
            lost     <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
            state    <= NORMAL;
        end else if (clear_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            seq      <= '0;
            lost     <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
            state    <= NORMAL;
        end else begin
            rd_ptr <= rd_ptr + LW'(pop);
            if (accept) begin
                wr_ptr <= wr_ptr + LW'(wr_cnt);
                seq    <= seq + SeqWidth'(wr_cnt);
                if (state == LOSSY) begin
                    lost  <= '0;
                    state <= NORMAL;
                end
            end else begin
                // All-or-nothing: the whole cycle's records are dropped and accounted.
                lost     <= sat_add(lost, n_rec);
                drop_cnt <= sat_add(drop_cnt, n_rec);
                overflow <= 1'b1;
                state    <= LOSSY;
            end
        end
    end

endmodule
